// File: rtl/crf_lite_master.sv
// rtl/crf_lite_master.sv - single-outstanding AXI4-Lite master with command/response handshake, timeout and updone flags
module crf_lite_master #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_write,
  output logic [1:0]                  rsp_resp,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                        timeout,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  input  logic [1:0]                  m_axi_bresp,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        interrupt_updone,
  output logic                        updone
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WB, S_RA, S_RD, S_RSP
  } state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_write_q, rsp_write_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      timeout_q, timeout_d;
  logic                      updone_q, updone_d;
  logic                      irq_hist_q, irq_hist_d;

  logic cmd_accept;
  logic wait_state;
  logic irq_rise;
  logic updone_clr;

  // Next-state, AXI channel and response register computation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;

    cmd_accept = (state_q == S_IDLE) && cmd_valid;
    wait_state = (state_q == S_WR) || (state_q == S_WB) ||
                 (state_q == S_RA) || (state_q == S_RD);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RA;
          end
        end
      end
      S_WR: begin
        // AW and W retire independently; B is only awaited once both are gone
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WB;
        end
      end
      S_WB: begin
        if (m_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          state_d     = S_RSP;
        end
      end
      S_RA: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        if (m_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_resp_d  = m_axi_rresp;
          rsp_rdata_d = m_axi_rdata;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Wait counter saturates so the timeout flag cannot wrap back off
    if (cmd_accept) begin
      cnt_d = '0;
    end else if (wait_state && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    timeout_d = !cmd_accept && (timeout_q || (cnt_d == CNT_MAX));

    // A fresh interrupt edge beats a simultaneous read-response clear
    irq_hist_d = interrupt_updone;
    irq_rise   = interrupt_updone && !irq_hist_q;
    updone_clr = (state_q == S_RSP) && rsp_ready && !rsp_write_q;
    updone_d   = irq_rise || (updone_q && !updone_clr);
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= 2'b00;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      updone_q    <= 1'b0;
      irq_hist_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      updone_q    <= updone_d;
      irq_hist_q  <= irq_hist_d;
    end
  end

  // cmd_ready is held low while rst is asserted, even if already in IDLE
  assign cmd_ready     = (state_q == S_IDLE) && !rst;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign timeout       = timeout_q;
  assign updone        = updone_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_crf_lite_master.sv
// tb/tb_crf_lite_master.sv - table-driven bench for crf_lite_master
module tb_crf_lite_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;
  logic        timeout;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = 2'b00;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        irq = 1'b0, updone;

  int checks = 0;
  int errors = 0;
  logic prev_to = 1'b0;

  crf_lite_master #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .timeout(timeout),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .interrupt_updone(irq), .updone(updone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    int          d_a;     // cycles before awready/arready
    int          d_w;     // cycles before wready
    int          d_r;     // cycles of bready/rready before bvalid/rvalid
    logic [1:0]  resp;
    logic [31:0] rd;
    int          hold;    // cycles rsp_ready is held low
    int          irq;     // 0 none, 1 pulse before command, 2 rise together with rsp_ready
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    logic        e_to;
    logic        e_upd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_irq();
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    @(negedge clk);
    chk("updone_set", updone, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int aw_hs, w_hs, ar_hs, bc;
    bit done;
    string t;
    t = $sformatf("v%0d", idx);
    if (v.irq == 1) pulse_irq();
    chk({t, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({t, "_to_idle"}, timeout, prev_to);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wd; cmd_wstrb = v.strb;
    @(negedge clk);
    cmd_valid = 1'b0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; bc = 0; done = 1'b0;
    bresp = v.resp; rresp = v.resp; rdata = v.rd;
    for (int c = 0; c < 64 && !done; c++) begin
      chk({t, "_to_wait"}, timeout, (c >= TO));
      chk({t, "_rsp_quiet"}, rsp_valid, 1'b0);
      chk({t, "_cmd_busy"}, cmd_ready, 1'b0);
      if (v.wr) begin
        chk({t, "_awvalid"}, awvalid, (aw_hs == 0));
        chk({t, "_wvalid"}, wvalid, (w_hs == 0));
        chk({t, "_bready"}, bready, (aw_hs == 1 && w_hs == 1));
        chk({t, "_no_ar"}, arvalid, 1'b0);
        if (awvalid) chk({t, "_awaddr"}, awaddr, v.addr);
        if (wvalid) begin
          chk({t, "_wdata"}, wdata, v.wd);
          chk({t, "_wstrb"}, wstrb, v.strb);
        end
        awready = awvalid && (c >= v.d_a);
        wready  = wvalid && (c >= v.d_w);
        bvalid  = bready && (bc >= v.d_r);
        done    = bvalid;
        if (bready) bc++;
        if (awvalid && awready) aw_hs++;
        if (wvalid && wready) w_hs++;
      end else begin
        chk({t, "_arvalid"}, arvalid, (ar_hs == 0));
        chk({t, "_rready"}, rready, (ar_hs == 1));
        chk({t, "_no_aw"}, awvalid | wvalid, 1'b0);
        if (arvalid) chk({t, "_araddr"}, araddr, v.addr);
        arready = arvalid && (c >= v.d_a);
        rvalid  = rready && (bc >= v.d_r);
        done    = rvalid;
        if (rready) bc++;
        if (arvalid && arready) ar_hs++;
      end
      @(negedge clk);
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s_txn_bound: got no B/R within 64 cycles expected completion", t);
    end
    if (v.wr) begin
      chk({t, "_aw_beats"}, aw_hs, 1);
      chk({t, "_w_beats"}, w_hs, 1);
    end
    for (int h = 0; h <= v.hold; h++) begin
      chk({t, "_rsp_valid"}, rsp_valid, 1'b1);
      chk({t, "_rsp_write"}, rsp_write, v.wr);
      chk({t, "_rsp_resp"}, rsp_resp, v.e_resp);
      chk({t, "_rsp_rdata"}, rsp_rdata, v.e_rdata);
      chk({t, "_cmd_ready_rsp"}, cmd_ready, 1'b0);
      chk({t, "_readies_low"}, bready | rready, 1'b0);
      if (h == v.hold) begin
        rsp_ready = 1'b1;
        if (v.irq == 2) irq = 1'b1;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    irq = 1'b0;
    chk({t, "_rsp_done"}, rsp_valid, 1'b0);
    chk({t, "_updone"}, updone, v.e_upd);
    chk({t, "_to_final"}, timeout, v.e_to);
    prev_to = v.e_to;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr   addr         wdata        strb  da dw dr resp  rdata        hold irq e_resp e_rdata      e_to  e_upd
    vecs[0] = '{1'b1, 32'h4,       32'h1,        4'hF, 0, 0, 0, 2'd0, 32'h0,        0,   0,  2'd0, 32'h0,        1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h10,      32'hA5A50F0F, 4'h3, 3, 0, 1, 2'd1, 32'hFFFFFFFF, 4,   0,  2'd1, 32'h0,        1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h8,       32'h0,        4'h0, 0, 0, 5, 2'd2, 32'hDEADBEEF, 0,   1,  2'd2, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h20,      32'h55,       4'hF, 0, 0, 20,2'd0, 32'h0,        1,   0,  2'd0, 32'h0,        1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'hC,       32'h0,        4'h0, 2, 0, 0, 2'd0, 32'h12345678, 0,   0,  2'd0, 32'h12345678, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h24,      32'h0BADF00D, 4'hC, 0, 0, 13,2'd3, 32'h0,        0,   0,  2'd3, 32'h0,        1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h28,      32'h0BADF00D, 4'hC, 0, 0, 14,2'd3, 32'h0,        0,   0,  2'd3, 32'h0,        1'b1, 1'b0};
    vecs[7] = '{1'b0, 32'h30,      32'h0,        4'h0, 0, 0, 0, 2'd3, 32'hCAFEF00D, 0,   2,  2'd3, 32'hCAFEF00D, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 32'h34,      32'h0,        4'h0, 1, 1, 0, 2'd2, 32'h0,        0,   0,  2'd2, 32'h0,        1'b0, 1'b1};
    vecs[9] = '{1'b0, 32'h38,      32'h0,        4'h0, 0, 0, 1, 2'd1, 32'h00000001, 0,   0,  2'd1, 32'h00000001, 1'b0, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    chk("rst_rsp", {rsp_write, rsp_resp, rsp_rdata}, 35'h0);
    chk("rst_flags", {timeout, updone}, 2'b00);
    chk("rst_prot", {awprot, arprot}, 6'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset while awaiting B aborts the transaction and clears updone
    pulse_irq();
    chk("wb_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h77; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    chk("wb_bready", bready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("wb_rst_bready", bready, 1'b0);
    chk("wb_rst_cmd_ready", cmd_ready, 1'b0);
    chk("wb_rst_valids", {awvalid, wvalid, arvalid, rready, rsp_valid}, 5'b0);
    chk("wb_rst_updone", updone, 1'b0);
    rst = 1'b0;
    bvalid = 1'b1;
    #1;
    chk("wb_release_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    bvalid = 1'b0;
    chk("wb_no_stale_rsp", rsp_valid, 1'b0);
    chk("wb_idle_timeout", timeout, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
